// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants, output state enum and saturating add for the MAC lane
package mac_pkg;

    localparam int IN_W_DEF  = 16;
    localparam int ACC_W_DEF = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    typedef struct packed {
        logic [63:0] value;
        logic        ovf;
    } sat_res_t;

    // Operands arrive sign-extended to 64 bits; w is the live accumulator width (w <= 63).
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int                 w,
                                         input logic               sat);
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        sat_res_t           r;
        s  = $signed({a[63], a}) + $signed({b[63], b});
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -hi - 65'sd1;
        r.ovf = (s > hi) || (s < lo);
        if (r.ovf && sat) begin
            r.value = s[64] ? lo[63:0] : hi[63:0];
        end else begin
            r.value = s[63:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/ripple_cpa.sv
// rtl/ripple_cpa.sv - W-bit ripple carry-propagate adder, carry-out dropped (mod 2^W result)
module ripple_cpa #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s
);

    logic [W:0] carry;
    logic       unused_cout;

    assign carry[0]    = 1'b0;
    assign unused_cout = carry[W];

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (s[i]),
            .co (carry[i+1])
        );
    end

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - resolves sum/carry rows, accumulates a dot-product group, holds the result
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int IN_W     = IN_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    input  logic [IN_W-1:0]  in_carry,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_overflow
);

    logic             p_valid;
    logic             p_last;
    logic [IN_W-1:0]  p;
    logic [IN_W-1:0]  cpa_sum;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    out_state_e       state;
    out_state_e       state_nxt;
    logic             a_accept;
    logic             in_fire;
    logic             consume;
    logic             last_consume;
    sat_res_t         add_res;
    logic [ACC_W-1:0] nxt;
    logic             nxt_ovf;
    logic             unused_hi;

    ripple_cpa #(.W(IN_W)) u_cpa (
        .a (in_sum),
        .b (in_carry),
        .s (cpa_sum)
    );

    // Only a last term can be held back, and only while an untaken result occupies the output.
    assign out_valid    = (state == FULL);
    assign a_accept     = !p_last || !out_valid || out_ready;
    assign in_ready     = !p_valid || a_accept;
    assign in_fire      = in_valid && in_ready;
    assign consume      = p_valid && a_accept;
    assign last_consume = consume && p_last;

    always_comb begin
        add_res = sat_add({{(64-ACC_W){acc[ACC_W-1]}}, acc},
                          {{(64-IN_W){p[IN_W-1]}}, p},
                          ACC_W, SATURATE);
        nxt     = add_res.value[ACC_W-1:0];
        nxt_ovf = ovf | add_res.ovf;
    end

    assign unused_hi = ^add_res.value[63:ACC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            p       <= '0;
        end else if (in_fire) begin
            p_valid <= 1'b1;
            p_last  <= in_last;
            p       <= cpa_sum;
        end else if (consume) begin
            p_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            ovf          <= 1'b0;
            out_data     <= '0;
            out_overflow <= 1'b0;
        end else if (consume) begin
            if (p_last) begin
                out_data     <= nxt;
                out_overflow <= nxt_ovf;
                acc          <= '0;
                ovf          <= 1'b0;
            end else begin
                acc <= nxt;
                ovf <= nxt_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (last_consume) state_nxt = FULL;
            FULL:  if (out_ready && !last_consume) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - randomized self-checking bench for mac_accumulator against a group-sum model
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_sum = '0;
    logic [15:0] in_carry = '0;

    logic        in_ready, out_valid, out_overflow;
    logic [31:0] out_data;
    logic        s_in_ready, s_out_valid, s_out_overflow;
    logic [15:0] s_out_data;
    logic        w_in_ready, w_out_valid, w_out_overflow;
    logic [15:0] w_out_data;

    int          errors = 0;
    int          checks = 0;
    int          n_terms;
    logic [15:0] t_sum [8];
    logic [15:0] t_carry [8];

    always #5 clk = ~clk;

    mac_accumulator #(.IN_W(16), .ACC_W(32), .SATURATE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_carry(in_carry), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_overflow(out_overflow));

    mac_accumulator #(.IN_W(16), .ACC_W(16), .SATURATE(1'b1)) dut_sat16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_sum(in_sum), .in_carry(in_carry), .in_last(in_last),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_overflow(s_out_overflow));

    mac_accumulator #(.IN_W(16), .ACC_W(16), .SATURATE(1'b0)) dut_wrap16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_sum(in_sum), .in_carry(in_carry), .in_last(in_last),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_data(w_out_data), .out_overflow(w_out_overflow));

    function automatic longint prod(input logic [15:0] s, input logic [15:0] c);
        longint v;
        v = (longint'(s) + longint'(c)) % 65536;
        if (v >= 32768) v -= 65536;
        return v;
    endfunction

    // Group result as a mathematician would compute it: running sum, clamp or wrap on range exit.
    function automatic longint model(input int w, input bit sat, output bit ovf);
        longint acc, span, hi, lo;
        span = longint'(1) << w;
        hi   = span / 2 - 1;
        lo   = -(span / 2);
        acc  = 0;
        ovf  = 1'b0;
        for (int i = 0; i < n_terms; i++) begin
            acc += prod(t_sum[i], t_carry[i]);
            if (acc > hi) begin
                ovf = 1'b1;
                acc = sat ? hi : acc - span;
            end else if (acc < lo) begin
                ovf = 1'b1;
                acc = sat ? lo : acc + span;
            end
        end
        return acc & (span - 1);
    endfunction

    task automatic send_beat(input logic [15:0] s, input logic [15:0] c, input bit last);
        int cyc = 0;
        in_valid = 1'b1;
        in_sum   = s;
        in_carry = c;
        in_last  = last;
        while (in_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_group();
        for (int i = 0; i < n_terms; i++) send_beat(t_sum[i], t_carry[i], i == n_terms - 1);
    endtask

    task automatic wait_out();
        int cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 20) begin
            checks++; errors++;
            $display("FAIL out_timeout out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial got v=%b r=%b d=%h o=%b required v=0 r=1 d=0 o=0",
                     out_valid, in_ready, out_data, out_overflow);
        end
        rst_n = 1'b1;
        out_ready = 1'b0;
        send_beat(16'h0005, 16'h0000, 1'b1);
        send_beat(16'h0007, 16'h0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
        checks++;
        if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h required 0", out_data); end
        checks++;
        if (out_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b required 0", out_overflow); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_beat(16'h0004, 16'h0000, 1'b1);
        wait_out();
        checks++;
        if (out_data !== 32'd4) begin errors++; $display("FAIL reset_first_group got %0d required 4", out_data); end
        @(negedge clk);
    endtask

    task automatic test_group_latency();
        out_ready = 1'b1;
        n_terms = 3;
        t_sum[0] = 16'h0003; t_carry[0] = 16'h0002;
        t_sum[1] = 16'hFFFF; t_carry[1] = 16'h0000;
        t_sum[2] = 16'h0010; t_carry[2] = 16'h0000;
        send_group();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early got out_valid=%b required 0", out_valid); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd20 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL group20 got v=%b d=%0d o=%b required v=1 d=20 o=0", out_valid, out_data, out_overflow);
        end
        @(negedge clk);
    endtask

    task automatic test_cpa_wrap();
        out_ready = 1'b1;
        send_beat(16'h8000, 16'h8000, 1'b1);
        wait_out();
        checks++;
        if (out_data !== 32'h0) begin errors++; $display("FAIL cpa_wrap_zero got %h required 00000000", out_data); end
        @(negedge clk);
        send_beat(16'h8000, 16'h0000, 1'b1);
        wait_out();
        checks++;
        if (out_data !== 32'hFFFF8000) begin errors++; $display("FAIL cpa_negative got %h required ffff8000", out_data); end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        send_beat(16'h7FFF, 16'h0000, 1'b0);
        send_beat(16'h0001, 16'h0000, 1'b1);
        wait_out();
        checks++;
        if (s_out_data !== 16'h7FFF || s_out_overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat16 got d=%h o=%b required d=7fff o=1", s_out_data, s_out_overflow);
        end
        checks++;
        if (w_out_data !== 16'h8000 || w_out_overflow !== 1'b1) begin
            errors++;
            $display("FAIL wrap16 got d=%h o=%b required d=8000 o=1", w_out_data, w_out_overflow);
        end
        checks++;
        if (out_data !== 32'h8000 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL acc32_no_ovf got d=%h o=%b required d=00008000 o=0", out_data, out_overflow);
        end
        @(negedge clk);
        send_beat(16'h0002, 16'h0000, 1'b1);
        wait_out();
        checks++;
        if (s_out_overflow !== 1'b0 || w_out_overflow !== 1'b0 || s_out_data !== 16'h2 || w_out_data !== 16'h2) begin
            errors++;
            $display("FAIL ovf_cleared got s=%h/%b w=%h/%b required 0002/0 0002/0",
                     s_out_data, s_out_overflow, w_out_data, w_out_overflow);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        longint e32, es, ew;
        bit     o32, os, ow;
        out_ready = 1'b1;
        for (int g = 0; g < 24; g++) begin
            n_terms = $urandom_range(1, 6);
            for (int i = 0; i < n_terms; i++) begin
                t_sum[i]   = 16'($urandom);
                t_carry[i] = 16'($urandom);
            end
            e32 = model(32, 1'b1, o32);
            es  = model(16, 1'b1, os);
            ew  = model(16, 1'b0, ow);
            send_group();
            wait_out();
            checks++;
            if (out_data !== e32[31:0] || out_overflow !== o32) begin
                errors++;
                $display("FAIL rand32 group %0d got %h/%b required %h/%b", g, out_data, out_overflow, e32[31:0], o32);
            end
            checks++;
            if (s_out_data !== es[15:0] || s_out_overflow !== os) begin
                errors++;
                $display("FAIL rand_sat16 group %0d got %h/%b required %h/%b", g, s_out_data, s_out_overflow, es[15:0], os);
            end
            checks++;
            if (w_out_data !== ew[15:0] || w_out_overflow !== ow) begin
                errors++;
                $display("FAIL rand_wrap16 group %0d got %h/%b required %h/%b", g, w_out_data, w_out_overflow, ew[15:0], ow);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        longint e1, e2;
        bit     o1, o2, acc_now;
        int     idx = 0;
        out_ready = 1'b0;
        n_terms = 2;
        t_sum[0] = 16'h1234; t_carry[0] = 16'h0101;
        t_sum[1] = 16'hF000; t_carry[1] = 16'h0002;
        e1 = model(32, 1'b1, o1);
        send_group();
        wait_out();
        n_terms = 4;
        for (int i = 0; i < 4; i++) begin
            t_sum[i]   = 16'($urandom);
            t_carry[i] = 16'($urandom);
        end
        e2 = model(32, 1'b1, o2);
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (idx < 4) begin
                in_valid = 1'b1;
                in_sum   = t_sum[idx];
                in_carry = t_carry[idx];
                in_last  = (idx == 3);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            acc_now = in_valid && in_ready;
            @(negedge clk);
            if (acc_now) idx++;
            checks++;
            if (out_valid !== 1'b1 || out_data !== e1[31:0] || out_overflow !== o1) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got v=%b d=%h required v=1 d=%h", cyc, out_valid, out_data, e1[31:0]);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (idx !== 4) begin errors++; $display("FAIL bp_absorbed got %0d beats required 4", idx); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_parked got in_ready=%b required 0", in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== e2[31:0] || out_overflow !== o2) begin
            errors++;
            $display("FAIL bp_second got v=%b d=%h/%b required v=1 d=%h/%b", out_valid, out_data, out_overflow, e2[31:0], o2);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_duplicate got out_valid=%b required 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send_beat(16'h0100, 16'h0023, 1'b1);
        send_beat(16'hFFF0, 16'h0000, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_0123) begin
            errors++;
            $display("FAIL b2b_first got v=%b d=%h required v=1 d=00000123", out_valid, out_data);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFF0) begin
            errors++;
            $display("FAIL b2b_second got v=%b d=%h required v=1 d=fffffff0", out_valid, out_data);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got out_valid=%b required 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_group_latency();
        test_cpa_wrap();
        test_overflow();
        test_random();
        test_backpressure();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
